// File: rtl/spi_sram_quad_writer_pkg.sv
// Shared SQI command codes, frame geometry and writer FSM encoding for the 23LC1024 write path.
package spi_sram_quad_writer_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_ESQI  = 8'h38;

    localparam int WRITE_NIBBLES = 12;
    localparam int ESQI_BITS     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
        ST_GAP,
        ST_INIT_REQ,
        ST_INIT_SHIFT
    } state_t;

endpackage

// File: rtl/spi_sram_quad_writer_shifter.sv
// Mode-0 SPI/SQI serialiser: each unit is driven with sck low for one clk, then sck high for one clk.
// A frame lasts 2*UNITS clks from start; done pulses in the final sck-high clk.
module spi_nibble_shifter #(
    parameter int LANES = 4,
    parameter int UNITS = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [LANES*UNITS-1:0] load_dat,
    input  logic                   start,
    output logic                   active,
    output logic                   sck,
    output logic                   done,
    output logic [LANES-1:0]       lane_dat
);

    localparam int DW    = LANES * UNITS;
    localparam int CNT_W = $clog2(UNITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(UNITS - 1);

    logic             active_q, active_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    sr_q, sr_d;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        done     = 1'b0;
        if (active_q) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (cnt_q == LAST) begin
                    active_d = 1'b0;
                    done     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sr_d  = sr_q << LANES;
                end
            end
        end
        if (load) begin
            sr_d = load_dat;
        end
        if (start) begin
            active_d = 1'b1;
            phase_d  = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
        end
    end

    // phase_q only ever sets while active, so it doubles as the idle-low mode-0 clock.
    assign sck      = phase_q;
    assign active   = active_q;
    assign lane_dat = sr_q[DW-1 -: LANES];

endmodule

// File: rtl/spi_sram_quad_writer.sv
// Single-word SQI WRITE master for the 23LC1024 (0x02, 24-bit addr, 2 bytes); SPI_WRITER_INIT_SQI_EN adds an ESQI boot step.
// cs_n low 24 clks from the grant edge, then CS_HIGH_CLKS idle; wr_ready stays low from acceptance until the gap ends.
module spi_sram_quad_writer
    import spi_sram_quad_writer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int CS_HIGH_CLKS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  busy,
    output logic                  sram_cs_n,
    output logic                  sram_sck,
    output logic                  sram_sio_oe,
    output logic                  sram_sio0_o,
    output logic                  sram_sio1_o,
    output logic                  sram_sio2_o,
    output logic                  sram_sio3_o
);

    localparam int GAP_W = $clog2(CS_HIGH_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_CLKS - 1);

`ifdef SPI_WRITER_INIT_SQI_EN
    localparam state_t RESET_STATE = ST_INIT_REQ;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             wr_start;
    logic             wr_active, wr_sck, wr_done;
    logic [3:0]       wr_lane;
    logic [23:0]      byte_addr;

    assign wr_ready  = (state_q == ST_IDLE);
    assign accept    = wr_valid && wr_ready;
    assign byte_addr = {{(23 - ADDR_WIDTH){1'b0}}, wr_addr, 1'b0};

    spi_nibble_shifter #(
        .LANES (4),
        .UNITS (WRITE_NIBBLES)
    ) u_wr_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_dat ({CMD_WRITE, byte_addr, wr_data}),
        .start    (wr_start),
        .active   (wr_active),
        .sck      (wr_sck),
        .done     (wr_done),
        .lane_dat (wr_lane)
    );

`ifdef SPI_WRITER_INIT_SQI_EN
    logic       init_load, init_start;
    logic       init_active, init_sck, init_done;
    logic [0:0] init_lane;

    spi_nibble_shifter #(
        .LANES (1),
        .UNITS (ESQI_BITS)
    ) u_init_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (init_load),
        .load_dat (CMD_ESQI),
        .start    (init_start),
        .active   (init_active),
        .sck      (init_sck),
        .done     (init_done),
        .lane_dat (init_lane)
    );
`endif

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        wr_start  = 1'b0;
`ifdef SPI_WRITER_INIT_SQI_EN
        init_load  = 1'b0;
        init_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_d  = ST_SHIFT;
                    wr_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (wr_done) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
`ifdef SPI_WRITER_INIT_SQI_EN
            ST_INIT_REQ: begin
                init_load = 1'b1;
                if (bus_grant) begin
                    state_d    = ST_INIT_SHIFT;
                    init_start = 1'b1;
                end
            end
            ST_INIT_SHIFT: begin
                if (init_done) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        busy_d = busy_q;
        if (accept) busy_d = 1'b1;
        else if (state_d == ST_IDLE) busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Request drops on the same edge the shifter goes inactive, i.e. when cs_n rises.
    assign bus_req = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                     (state_q == ST_INIT_REQ) || (state_q == ST_INIT_SHIFT);
    assign busy    = busy_q;

`ifdef SPI_WRITER_INIT_SQI_EN
    // ESQI goes out in single-bit mode on sio0 with HOLD_N and the spare lines held high.
    assign sram_cs_n   = ~(wr_active | init_active);
    assign sram_sck    = wr_sck | init_sck;
    assign sram_sio_oe = wr_active | init_active;
    assign sram_sio0_o = wr_active ? wr_lane[0] : (init_active & init_lane[0]);
    assign sram_sio1_o = wr_active ? wr_lane[1] : init_active;
    assign sram_sio2_o = wr_active ? wr_lane[2] : init_active;
    assign sram_sio3_o = wr_active ? wr_lane[3] : init_active;
`else
    assign sram_cs_n   = ~wr_active;
    assign sram_sck    = wr_sck;
    assign sram_sio_oe = wr_active;
    assign sram_sio0_o = wr_active & wr_lane[0];
    assign sram_sio1_o = wr_active & wr_lane[1];
    assign sram_sio2_o = wr_active & wr_lane[2];
    assign sram_sio3_o = wr_active & wr_lane[3];
`endif

endmodule

// File: tb/tb_spi_sram_quad_writer.sv
// Bench for spi_sram_quad_writer: a 23LC1024 pin-level model decodes frames into a byte memory,
// compared against an expected memory built from the accepted write requests.
`timescale 1ns/1ps
module tb_spi_sram_quad_writer;

    localparam int AW  = 16;
    localparam int CSH = 2;
`ifdef SPI_WRITER_INIT_SQI_EN
    localparam logic EXP_RDY0 = 1'b0;
    localparam bit   SQI_AT_START = 1'b0;
`else
    localparam logic EXP_RDY0 = 1'b1;
    localparam bit   SQI_AT_START = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          bus_grant = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          wr_ready, bus_req, busy;
    logic          sram_cs_n, sram_sck, sram_sio_oe;
    logic          sram_sio0_o, sram_sio1_o, sram_sio2_o, sram_sio3_o;

    spi_sram_quad_writer #(.ADDR_WIDTH(AW), .CS_HIGH_CLKS(CSH)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .bus_req(bus_req), .bus_grant(bus_grant),
        .busy(busy), .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_sio_oe(sram_sio_oe),
        .sram_sio0_o(sram_sio0_o), .sram_sio1_o(sram_sio1_o),
        .sram_sio2_o(sram_sio2_o), .sram_sio3_o(sram_sio3_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- 23LC1024 pin model ----------------
    logic [7:0] mem     [int];
    logic [7:0] exp_mem [int];
    logic [3:0] nq[$];
    logic [3:0] last_nq[$];
    bit         sqi_mode = SQI_AT_START;
    logic [7:0] spi_val = '0;
    int         spi_n = 0;
    logic [7:0] last_spi = '0;
    int         last_spi_n = 0;
    int         frame_cnt = 0;
    int         ma;

    always @(posedge sram_sck) begin
        if (sram_cs_n === 1'b0) begin
            if (sqi_mode) nq.push_back({sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o});
            else begin
                spi_val = {spi_val[6:0], sram_sio0_o};
                spi_n++;
            end
        end
    end

    always @(posedge sram_cs_n) begin
        if (!sqi_mode && spi_n != 0) begin
            last_spi   = spi_val;
            last_spi_n = spi_n;
            if (spi_n == 8 && spi_val == 8'h38) sqi_mode = 1'b1;
            spi_n = 0;
        end else if (sqi_mode && nq.size() != 0) begin
            frame_cnt++;
            last_nq = nq;
            if (nq.size() >= 8 && {nq[0], nq[1]} == 8'h02) begin
                ma = 0;
                for (int i = 2; i < 8; i++) ma = ma * 16 + int'(nq[i]);
                for (int b = 0; 9 + 2 * b < nq.size(); b++) mem[ma + b] = {nq[8 + 2 * b], nq[9 + 2 * b]};
            end
            nq.delete();
        end
    end

    function automatic logic [63:0] frame_val();
        logic [63:0] v = '0;
        foreach (last_nq[i]) v = (v << 4) | 64'(last_nq[i]);
        return v;
    endfunction

    // ---------------- pin-level rule monitor ----------------
    int   viol = 0;
    int   low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    logic prev_cs_n = 1'b1;

    always @(negedge clk) begin
        if (!reset) begin
            if (sram_cs_n === 1'b1 && sram_sck !== 1'b0) viol++;
            if (sram_cs_n === 1'b0 && (bus_req !== 1'b1 || sram_sio_oe !== 1'b1)) viol++;
            if (busy === 1'b1 && wr_ready === 1'b1) viol++;
            if (prev_cs_n === 1'b0 && sram_cs_n === 1'b1 && bus_req !== 1'b0) viol++;
        end
        if (sram_cs_n === 1'b0) begin
            if (high_run != 0) begin last_high = high_run; high_run = 0; end
            low_run++;
        end else begin
            if (low_run != 0) begin last_low = low_run; low_run = 0; end
            high_run++;
        end
        prev_cs_n = sram_cs_n;
    end

    // gdelay < 0: grant is left as the caller set it; otherwise grant rises gdelay clks after bus_req.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int gdelay,
                            input bit churn, input string tag);
        int n;
        int fc0;
        int cs_bad;
        int busy_bad;
        n = 0;
        while (wr_ready !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        check_val({tag, "_ready_wait"}, 64'(n < 2000), 64'd1);
        fc0 = frame_cnt;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        exp_mem[int'(a) * 2]     = d[15:8];
        exp_mem[int'(a) * 2 + 1] = d[7:0];
        if (!churn) wr_valid = 1'b0;
        else wr_data = 16'($urandom);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        check_val({tag, "_rdy_low"}, 64'(wr_ready), 64'd0);
        if (gdelay >= 0) begin
            cs_bad   = 0;
            busy_bad = 0;
            repeat (gdelay) begin
                @(posedge clk); #1;
                if (sram_cs_n !== 1'b1 || sram_sck !== 1'b0 || bus_req !== 1'b1) cs_bad++;
                if (busy !== 1'b1) busy_bad++;
                if (churn) wr_data = 16'($urandom);
            end
            check_val({tag, "_idle_pre_grant"}, 64'(cs_bad), 64'd0);
            check_val({tag, "_busy_pre_grant"}, 64'(busy_bad), 64'd0);
            bus_grant = 1'b1;
            @(posedge clk); #1;
            check_val({tag, "_cs_on_grant"}, 64'(sram_cs_n), 64'd0);
        end
        n = 0;
        while (bus_req === 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
            if (churn) wr_data = 16'($urandom);
        end
        check_val({tag, "_req_drop"}, 64'(n < 200), 64'd1);
        if (gdelay >= 0) bus_grant = 1'b0;
        n = 0;
        while (wr_ready !== 1'b1 && n < 50) begin
            if (churn) wr_data = 16'($urandom);
            @(posedge clk); #1; n++;
        end
        wr_valid = 1'b0;
        check_val({tag, "_ready_back"}, 64'(n < 50), 64'd1);
        check_val({tag, "_frames"}, 64'(frame_cnt - fc0), 64'd1);
        check_val({tag, "_nibbles"}, 64'(last_nq.size()), 64'd12);
        check_val({tag, "_frame"}, frame_val(), (64'h02 << 40) | (64'(a) << 17) | 64'(d));
        check_val({tag, "_cs_low_clks"}, 64'(last_low), 64'd24);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int gd;
        logic [15:0] ra, rd;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wr_ready", 64'(wr_ready), 64'(EXP_RDY0));
        check_val("rst_bus_req", 64'(bus_req), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_cs_n", 64'(sram_cs_n), 64'd1);
        check_val("rst_sck", 64'(sram_sck), 64'd0);
        check_val("rst_oe", 64'(sram_sio_oe), 64'd0);
        check_val("rst_sio", 64'({sram_sio3_o, sram_sio2_o, sram_sio1_o, sram_sio0_o}), 64'd0);
        reset = 1'b0;

`ifdef SPI_WRITER_INIT_SQI_EN
        repeat (5) @(posedge clk);
        #1;
        check_val("init_req", 64'(bus_req), 64'd1);
        check_val("init_rdy_low", 64'(wr_ready), 64'd0);
        check_val("init_cs_idle", 64'(sram_cs_n), 64'd1);
        bus_grant = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 200) begin
            check_val("init_rdy_vs_sqi", 64'(wr_ready), 64'd0);
            @(posedge clk); #1; n++;
        end
        check_val("init_done", 64'(n < 200), 64'd1);
        check_val("init_sqi_mode", 64'(sqi_mode), 64'd1);
        check_val("init_cmd", 64'(last_spi), 64'h38);
        check_val("init_bits", 64'(last_spi_n), 64'd8);
`endif

        // grant tied high
        bus_grant = 1'b1;
        do_write(16'h0010, 16'hBEEF, -1, 1'b0, "t1");
        check_val("t1_mem20", 64'(mem.exists(32'h20) ? mem[32'h20] : 8'hxx), 64'hBE);
        check_val("t1_mem21", 64'(mem.exists(32'h21) ? mem[32'h21] : 8'hxx), 64'hEF);

        // grant delayed 10 clks
        bus_grant = 1'b0;
        do_write(16'h0010, 16'hBEEF, 10, 1'b0, "t2");

        // back-to-back
        bus_grant = 1'b1;
        do_write(16'h0000, 16'h1234, -1, 1'b0, "t3a");
        do_write(16'h0001, 16'h5678, -1, 1'b0, "t3b");
        check_val("t3_cs_high_gap", 64'(last_high >= CSH), 64'd1);
        check_val("t3_readback",
                  64'({mem.exists(0) ? mem[0] : 8'hxx, mem.exists(1) ? mem[1] : 8'hxx,
                       mem.exists(2) ? mem[2] : 8'hxx, mem.exists(3) ? mem[3] : 8'hxx}),
                  64'h12345678);

        // reset at nibble 6
        n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        wr_valid = 1'b1; wr_addr = 16'h0040; wr_data = 16'hA5A5;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        n = 0;
        while (nq.size() < 6 && n < 100) begin @(posedge clk); #1; n++; end
        check_val("t4_reach_nib6", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("t4_cs_n", 64'(sram_cs_n), 64'd1);
        check_val("t4_sck", 64'(sram_sck), 64'd0);
        check_val("t4_oe", 64'(sram_sio_oe), 64'd0);
        check_val("t4_wr_ready", 64'(wr_ready), 64'(EXP_RDY0));
        check_val("t4_bus_req", 64'(bus_req), 64'd0);
        check_val("t4_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        check_val("t4_mem_untouched", 64'(mem.exists(32'h80) || mem.exists(32'h81)), 64'd0);

        // wr_valid held with churning data while busy
        bus_grant = 1'b0;
        do_write(16'h0100, 16'hC0DE, 3, 1'b1, "t5");
        bus_grant = 1'b1;
        do_write(16'h0101, 16'h7777, -1, 1'b0, "t5b");

        // randomized writes, first one at the top word address
        for (int i = 0; i < 20; i++) begin
            ra = (i == 0) ? 16'hFFFF : 16'($urandom);
            rd = 16'($urandom);
            gd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 6));
            bus_grant = (gd < 0);
            do_write(ra, rd, gd, 1'b0, "rnd");
        end
        check_val("max_addr_hi", 64'(mem.exists(32'h1FFFE)), 64'd1);

        foreach (exp_mem[k])
            check_val("mem", mem.exists(k) ? 64'(mem[k]) : 64'hDEAD, 64'(exp_mem[k]));
        check_val("pin_rules", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
